// File: rtl/simon_cbc_ctrl.sv
// CBC chaining controller in front of a SIMON 48/72 core.
// Optional ECB bypass port enabled by defining SIMON_CBC_ECB_BYPASS_EN.
module simon_cbc_ctrl #(
   parameter int N = 24
) (
   input  logic           clk,
   input  logic           nR,
   input  logic           mode_dec,
   input  logic           iv_load,
   input  logic [2*N-1:0] iv,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_data,
`ifdef SIMON_CBC_ECB_BYPASS_EN
   input  logic           ecb_mode,
`endif
   input  logic           doneKey,
   output logic           newData,
   output logic [2*N-1:0] plain,
   output logic           enc_dec,
   input  logic           ldData,
   input  logic           doneData,
   output logic           readData,
   input  logic [2*N-1:0] cipher
);

   localparam int W = 2 * N;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      BUSY,
      ACK
   } state_t;

   state_t         state;
   logic           dec_q;
   logic           ecb_q;
   logic [W-1:0]   chain;
   logic [W-1:0]   saved_in;

   logic           ecb_in;
   logic           accept;
   logic           out_free;
   logic [W-1:0]   in_mask;
   logic [W-1:0]   run_mask;

`ifdef SIMON_CBC_ECB_BYPASS_EN
   assign ecb_in = ecb_mode;
`else
   assign ecb_in = 1'b0;
`endif

   // iv_load wins over a block offered in the same cycle
   assign in_ready = (state == IDLE) & doneKey & ~iv_load;
   assign accept   = in_valid & in_ready;

   // output register may be overwritten when empty or drained this cycle
   assign out_free = ~out_valid | out_ready;

   // ECB blocks see an all-zero chain value
   assign in_mask  = ecb_in ? '0 : chain;
   assign run_mask = ecb_q ? '0 : chain;

   // block sequencer: host accept, core load, core result, core acknowledge
   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         state     <= IDLE;
         dec_q     <= 1'b0;
         ecb_q     <= 1'b0;
         chain     <= '0;
         saved_in  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         newData   <= 1'b0;
         readData  <= 1'b0;
         plain     <= '0;
         enc_dec   <= 1'b1;
      end else begin
         if (out_valid & out_ready) begin
            out_valid <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (iv_load) begin
                  chain <= iv;
               end else if (accept) begin
                  dec_q   <= mode_dec;
                  ecb_q   <= ecb_in;
                  newData <= 1'b1;
                  state   <= LOAD;
                  if (mode_dec) begin
                     plain    <= in_data;
                     saved_in <= in_data;
                     enc_dec  <= 1'b0;
                  end else begin
                     plain   <= in_data ^ in_mask;
                     enc_dec <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (ldData) begin
                  newData <= 1'b0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (doneData & out_free) begin
                  out_valid <= 1'b1;
                  readData  <= 1'b1;
                  state     <= ACK;
                  if (dec_q) begin
                     out_data <= cipher ^ run_mask;
                     if (!ecb_q) begin
                        chain <= saved_in;
                     end
                  end else begin
                     out_data <= cipher;
                     if (!ecb_q) begin
                        chain <= cipher;
                     end
                  end
               end
            end
            ACK: begin
               if (!doneData) begin
                  readData <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simon_cbc_ctrl.sv
// Bench for simon_cbc_ctrl with a behavioural SIMON 48/72 core
// and a CBC reference model built from plain block arithmetic.
module tb_simon_cbc_ctrl;

   localparam int N = 24;
   localparam int W = 48;
   localparam logic [71:0] KEY = 72'h121110_0A0908_020100;
   localparam logic [61:0] Z0 =
      62'b11111010001001010110000111001101111101000100101011000011100110;

   logic         clk = 1'b0;
   logic         nR = 1'b0;
   logic         mode_dec = 1'b0;
   logic         iv_load = 1'b0;
   logic [W-1:0] iv = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         ecb_mode = 1'b0;
   logic         doneKey = 1'b0;
   logic         newData;
   logic [W-1:0] plain;
   logic         enc_dec;
   logic         ldData;
   logic         doneData;
   logic         readData;
   logic [W-1:0] cipher;

   int checks = 0;
   int failures = 0;
   int rdy_mode = 0;
   int plain_bad = 0;

   logic [23:0]  rk [36];
   logic [W-1:0] chain_m = '0;
   logic [W-1:0] exp_q [$];
   logic [W-1:0] got_q [$];
   logic [W-1:0] seen [$];

   simon_cbc_ctrl #(.N(N)) dut (
      .clk(clk),
      .nR(nR),
      .mode_dec(mode_dec),
      .iv_load(iv_load),
      .iv(iv),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
`ifdef SIMON_CBC_ECB_BYPASS_EN
      .ecb_mode(ecb_mode),
`endif
      .doneKey(doneKey),
      .newData(newData),
      .plain(plain),
      .enc_dec(enc_dec),
      .ldData(ldData),
      .doneData(doneData),
      .readData(readData),
      .cipher(cipher)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] rotl(input logic [23:0] x, input int s);
      return (x << s) | (x >> (24 - s));
   endfunction

   function automatic logic [23:0] rotr(input logic [23:0] x, input int s);
      return (x >> s) | (x << (24 - s));
   endfunction

   function automatic logic [23:0] rf(input logic [23:0] x);
      return (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
   endfunction

   task automatic key_expand();
      logic [23:0] t;
      rk[0] = KEY[23:0];
      rk[1] = KEY[47:24];
      rk[2] = KEY[71:48];
      for (int i = 3; i < 36; i++) begin
         t = rotr(rk[i-1], 3);
         t = t ^ rotr(t, 1);
         rk[i] = ~rk[i-3] ^ t ^ {23'd0, Z0[61-((i-3)%62)]} ^ 24'd3;
      end
   endtask

   function automatic logic [W-1:0] simon_enc(input logic [W-1:0] p);
      logic [23:0] x, y, t;
      x = p[47:24];
      y = p[23:0];
      for (int i = 0; i < 36; i++) begin
         t = x;
         x = y ^ rf(x) ^ rk[i];
         y = t;
      end
      return {x, y};
   endfunction

   function automatic logic [W-1:0] simon_dec(input logic [W-1:0] c);
      logic [23:0] x, y, t;
      x = c[47:24];
      y = c[23:0];
      for (int i = 35; i >= 0; i--) begin
         t = y;
         y = x ^ rf(y) ^ rk[i];
         x = t;
      end
      return {x, y};
   endfunction

   // behavioural core: latch on newData, compute, hold result until readData
   int           cst;
   int           ccnt;
   logic [W-1:0] cblk;
   logic         cenc;
   always @(posedge clk or negedge nR) begin
      if (!nR) begin
         cst      <= 0;
         ccnt     <= 0;
         ldData   <= 1'b0;
         doneData <= 1'b0;
         cipher   <= '0;
         cblk     <= '0;
         cenc     <= 1'b1;
      end else begin
         case (cst)
            0: if (newData) begin
               cblk   <= plain;
               cenc   <= enc_dec;
               ldData <= 1'b1;
               ccnt   <= $urandom_range(3, 8);
               cst    <= 1;
            end
            1: begin
               ldData <= 1'b0;
               if (ccnt == 0) begin
                  cipher   <= cenc ? simon_enc(cblk) : simon_dec(cblk);
                  doneData <= 1'b1;
                  cst      <= 2;
               end else begin
                  ccnt <= ccnt - 1;
               end
            end
            default: if (readData) begin
               doneData <= 1'b0;
               cst      <= 0;
            end
         endcase
      end
   end

   // plain must stay put while the core works on it
   always @(negedge clk) begin
      if (nR && cst == 1 && plain !== cblk) plain_bad++;
   end

   // host output side
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'b0;
      else out_ready = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (nR && out_valid && out_ready) got_q.push_back(out_data);
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic void model_push(input logic [W-1:0] d, input logic dec,
                                      input logic ecb);
      logic [W-1:0] r;
      if (!dec) begin
         r = simon_enc(d ^ (ecb ? '0 : chain_m));
         if (!ecb) chain_m = r;
      end else begin
         r = simon_dec(d) ^ (ecb ? '0 : chain_m);
         if (!ecb) chain_m = d;
      end
      exp_q.push_back(r);
   endfunction

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("idle_wait", in_ready, 1);
   endtask

   task automatic load_iv(input logic [W-1:0] v);
      wait_idle();
      iv_load = 1'b1;
      iv = v;
      @(negedge clk);
      iv_load = 1'b0;
      chain_m = v;
   endtask

   task automatic send(input logic [W-1:0] d, input logic dec);
      int t = 0;
      in_valid = 1'b1;
      in_data = d;
      mode_dec = dec;
      forever begin
         #1;
         if (in_ready) break;
         @(negedge clk);
         t++;
         if (t > 500) break;
      end
      if (in_ready) begin
         model_push(d, dec, ecb_mode);
         @(posedge clk);
      end else begin
         check("accept_wait", in_ready, 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (got_q.size() < exp_q.size() && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("drain_count", 64'(got_q.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         seen.push_back(got_q[0]);
         check("out_data", got_q.pop_front(), exp_q.pop_front());
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_newData"}, newData, 0);
      check({tag, "_readData"}, readData, 0);
      check({tag, "_plain"}, plain, 0);
      check({tag, "_enc_dec"}, enc_dec, 1);
   endtask

   initial begin
      logic [W-1:0] held;
      logic [W-1:0] c1;
      logic [W-1:0] c2;
      logic [W-1:0] d;
      int t;
      key_expand();

      // reset values
      #12;
      check_reset_outputs("rst");
      @(negedge clk);
      nR = 1'b1;
      @(negedge clk);
      check("rst_nokey_in_ready", in_ready, 0);
      doneKey = 1'b1;
      #1;
      check("rst_key_in_ready", in_ready, 1);

      // known-answer first block and CBC encrypt/decrypt round trip
      seen.delete();
      load_iv('0);
      send(48'h6120676E696C, 1'b0);
      send(48'hA8D5F7DE0123, 1'b0);
      drain();
      c1 = seen[0];
      c2 = seen[1];
      check("kat_enc", c1, 48'hDAE5AC292CAC);
      seen.delete();
      load_iv('0);
      send(c1, 1'b1);
      send(c2, 1'b1);
      drain();
      check("rt_dec0", seen[0], 48'h6120676E696C);
      check("rt_dec1", seen[1], 48'hA8D5F7DE0123);

      // output backpressure stalls the second block in BUSY
      rdy_mode = 1;
      load_iv(48'h0123456789AB);
      send(48'h111122223333, 1'b0);
      t = 0;
      while (!out_valid && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("bp_first_valid", out_valid, 1);
      held = out_data;
      send(48'h444455556666, 1'b0);
      repeat (20) @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_hold", out_data, held);
      check("bp_readData", readData, 0);
      check("bp_doneData", doneData, 1);
      check("bp_in_ready", in_ready, 0);
      rdy_mode = 0;
      drain();

      // key gating, then iv_load and in_valid in the same cycle
      wait_idle();
      doneKey = 1'b0;
      in_valid = 1'b1;
      in_data = 48'hCAFEF00DBEEF;
      mode_dec = 1'b0;
      repeat (4) @(negedge clk);
      check("gate_in_ready", in_ready, 0);
      check("gate_newData", newData, 0);
      in_valid = 1'b0;
      doneKey = 1'b1;
      @(negedge clk);
      d = 48'h5A5A00FF1234;
      iv_load = 1'b1;
      iv = 48'h9876543210FE;
      in_valid = 1'b1;
      in_data = d;
      #1;
      check("prio_in_ready", in_ready, 0);
      @(negedge clk);
      iv_load = 1'b0;
      chain_m = 48'h9876543210FE;
      #1;
      check("prio_next_ready", in_ready, 1);
      model_push(d, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("prio_newData", newData, 1);
      drain();

      // randomized traffic against the CBC model
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            drain();
            load_iv({$urandom(), 16'($urandom())});
         end
         send({$urandom(), 16'($urandom())}, 1'($urandom_range(0, 1)));
      end
      drain();
      rdy_mode = 0;

`ifdef SIMON_CBC_ECB_BYPASS_EN
      // ECB bypass: identical blocks give identical results
      seen.delete();
      load_iv(48'hFFFF0000FFFF);
      ecb_mode = 1'b1;
      send(48'h6120676E696C, 1'b0);
      send(48'h6120676E696C, 1'b0);
      drain();
      check("ecb_0", seen[0], 48'hDAE5AC292CAC);
      check("ecb_1", seen[1], 48'hDAE5AC292CAC);
      ecb_mode = 1'b0;
`endif

      // asynchronous reset while the core is busy
      wait_idle();
      send(48'h0F0F0F0F0F0F, 1'b0);
      t = 0;
      while ((newData || readData || doneData) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("busy_reached", {newData, readData, in_ready}, 3'b000);
      #2;
      nR = 1'b0;
      doneKey = 1'b0;
      #1;
      check_reset_outputs("busy_rst");
      exp_q.delete();
      got_q.delete();
      chain_m = '0;
      repeat (2) @(negedge clk);
      nR = 1'b1;
      @(negedge clk);
      doneKey = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1);
      send(48'h6120676E696C, 1'b0);
      drain();

      check("plain_stable", 64'(plain_bad), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
